// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multicycle MIPS-subset core with a shared ALU and one req/ready memory port
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic        ENABLE_BNE = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic [3:0]  state,
  output logic        retire,
  output logic        illegal
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
  } state_t;
  state_t st;
  logic [31:0] ir, a, b, alu_out, data;
  logic [31:0] rf [32];
  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd, wa;
  logic [31:0] imm, rd_a, rd_b, alu_a, alu_b, alu_y, wd;
  logic op_lw, op_sw, op_r, op_beq, op_bne, op_addi, op_j, legal, rf_we;
  always_comb begin
    op      = ir[31:26];
    rs      = ir[25:21];
    rt      = ir[20:16];
    rd      = ir[15:11];
    funct   = ir[5:0];
    imm     = {{16{ir[15]}}, ir[15:0]};
    op_lw   = op == 6'h23;
    op_sw   = op == 6'h2B;
    op_r    = op == 6'h00;
    op_beq  = op == 6'h04;
    op_bne  = op == 6'h05 && ENABLE_BNE;
    op_addi = op == 6'h08;
    op_j    = op == 6'h02;
    legal   = op_lw || op_sw || op_beq || op_bne || op_addi || op_j ||
              (op_r && funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A});
    rd_a    = rs == 5'd0 ? '0 : rf[rs];
    rd_b    = rt == 5'd0 ? '0 : rf[rt];
    alu_a   = st == FETCH || st == DECODE ? pc : a;
    alu_b   = st == FETCH ? 32'd4 : st == DECODE ? {imm[29:0], 2'b00} : st == EXEC ? b : imm;
    alu_y   = st != EXEC      ? alu_a + alu_b :
              funct == 6'h22  ? alu_a - alu_b :
              funct == 6'h24  ? alu_a & alu_b :
              funct == 6'h25  ? alu_a | alu_b :
              funct == 6'h2A  ? {31'd0, $signed(alu_a) < $signed(alu_b)} : alu_a + alu_b;
    wa      = st == ALUWB ? rd : rt;
    wd      = st == MEMWB ? data : alu_out;
    rf_we   = !reset_n && (st == MEMWB || st == ALUWB || st == ADDIWB) && wa != 5'd0;
    mem_req   = !reset_n && (st == FETCH || st == MEMRD || st == MEMWR);
    mem_we    = st == MEMWR;
    mem_addr  = st == FETCH ? pc : alu_out;
    mem_wdata = b;
    state     = st;
    retire    = !reset_n && (st == MEMWB || st == ALUWB || st == ADDIWB || st == BRANCH ||
                             st == JUMP || (st == MEMWR && mem_ready));
    illegal   = !reset_n && st == DECODE && !legal;
  end
  always_ff @(posedge clk) if (rf_we) rf[wa] <= wd;
  always_ff @(posedge clk) begin
    if (reset_n) begin
      st      <= FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      data    <= '0;
    end else begin
      case (st)
        FETCH: if (mem_ready) begin
          ir <= mem_rdata;
          pc <= alu_y;
          st <= DECODE;
        end
        DECODE: begin
          a       <= rd_a;
          b       <= rd_b;
          alu_out <= alu_y;
          st      <= !legal ? FETCH : op_lw || op_sw ? MEMADR : op_r ? EXEC :
                     op_beq || op_bne ? BRANCH : op_addi ? ADDIEX : JUMP;
        end
        MEMADR: begin
          alu_out <= alu_y;
          st      <= op_lw ? MEMRD : MEMWR;
        end
        MEMRD: if (mem_ready) begin
          data <= mem_rdata;
          st   <= MEMWB;
        end
        MEMWR: if (mem_ready) st <= FETCH;
        EXEC: begin
          alu_out <= alu_y;
          st      <= ALUWB;
        end
        ADDIEX: begin
          alu_out <= alu_y;
          st      <= ADDIWB;
        end
        BRANCH: begin
          if (op_beq ? a == b : a != b) pc <= alu_out;
          st <= FETCH;
        end
        JUMP: begin
          pc <= {pc[31:28], ir[25:0], 2'b00};
          st <= FETCH;
        end
        default: st <= FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb_mips_multicycle_core: directed program tables for two core configurations plus reset-abort sequence
module tb_mips_multicycle_core;
  typedef struct {
    int          g;
    logic [31:0] ia;
    logic [31:0] instr;
    int          waits;
    int          cyc;
    logic [31:0] npc;
    int          wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    int          ill;
  } vec_t;
  logic clk = 1'b0;
  logic rst [2];
  logic req [2], we [2], ready [2], retire [2], illegal [2];
  logic [31:0] addr [2], wdata [2], rdata [2], pc [2];
  logic [3:0] state [2];
  logic [31:0] mem [2][256];
  int wcnt [2], ret_tot [2], ill_tot [2];
  logic hold [2], hwe [2], wr_seen [2];
  logic [31:0] haddr [2], hwdata [2], wr_addr [2], wr_data [2];
  int waits, unstable, checks, errors;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    mips_multicycle_core #(
      .RESET_PC(g == 0 ? 32'h0000_0100 : 32'h1000_0000),
      .ENABLE_BNE(g == 0)
    ) dut (
      .clk(clk),
      .reset_n(rst[g]),
      .mem_req(req[g]),
      .mem_we(we[g]),
      .mem_addr(addr[g]),
      .mem_wdata(wdata[g]),
      .mem_rdata(rdata[g]),
      .mem_ready(ready[g]),
      .pc(pc[g]),
      .state(state[g]),
      .retire(retire[g]),
      .illegal(illegal[g])
    );
  end
  function automatic vec_t mk(input int g, input logic [31:0] ia, instr, input int w, c,
                              input logic [31:0] npc, input int wr, input logic [31:0] wa, wd,
                              input int il);
    vec_t v;
    v.g = g; v.ia = ia; v.instr = instr; v.waits = w; v.cyc = c;
    v.npc = npc; v.wr = wr; v.waddr = wa; v.wdata = wd; v.ill = il;
    return v;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic cycle();
    for (int g = 0; g < 2; g++) begin
      rdata[g] = mem[g][addr[g][9:2]];
      ready[g] = wcnt[g] == waits;
    end
    #1;
    for (int g = 0; g < 2; g++) begin
      if (req[g] && hold[g] && (addr[g] != haddr[g] || we[g] != hwe[g] || (we[g] && wdata[g] != hwdata[g])))
        unstable++;
      hold[g] = req[g] && !ready[g];
      haddr[g] = addr[g];
      hwe[g] = we[g];
      hwdata[g] = wdata[g];
      if (req[g] && we[g] && ready[g]) begin
        mem[g][addr[g][9:2]] = wdata[g];
        wr_seen[g] = 1'b1;
        wr_addr[g] = addr[g];
        wr_data[g] = wdata[g];
      end
      if (retire[g]) ret_tot[g]++;
      if (illegal[g]) ill_tot[g]++;
    end
    @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) wcnt[g] = hold[g] ? wcnt[g] + 1 : 0;
  endtask
  task automatic run(input int g, output int cyc);
    int base;
    base = ret_tot[g] + ill_tot[g];
    cyc = 0;
    wr_seen[g] = 1'b0;
    while (ret_tot[g] + ill_tot[g] == base && cyc < 40) begin
      cycle();
      cyc++;
    end
  endtask
  task automatic apply(input vec_t v, output int cyc);
    int il;
    waits = v.waits;
    il = ill_tot[v.g];
    run(v.g, cyc);
    chk($sformatf("cycles@%h", v.ia), cyc, v.cyc);
    chk($sformatf("next_pc@%h", v.ia), pc[v.g], v.npc);
    chk($sformatf("next_fetch@%h", v.ia), addr[v.g], v.npc);
    chk($sformatf("illegal@%h", v.ia), ill_tot[v.g] - il, v.ill);
    chk($sformatf("write_seen@%h", v.ia), 32'(wr_seen[v.g]), v.wr);
    if (v.wr != 0) begin
      chk($sformatf("write_addr@%h", v.ia), wr_addr[v.g], v.waddr);
      chk($sformatf("write_data@%h", v.ia), wr_data[v.g], v.wdata);
    end
  endtask
  initial begin
    vec_t tv [$];
    int cyc, sum, r0;
    tv.push_back(mk(0, 32'h100, 32'h20010005, 0, 4, 32'h104, 0, 0, 0, 0));
    tv.push_back(mk(0, 32'h104, 32'h20020007, 0, 4, 32'h108, 0, 0, 0, 0));
    tv.push_back(mk(0, 32'h108, 32'h00221820, 0, 4, 32'h10C, 0, 0, 0, 0));
    tv.push_back(mk(0, 32'h10C, 32'hAC030008, 2, 8, 32'h110, 1, 32'h8, 32'd12, 0));
    tv.push_back(mk(0, 32'h110, 32'h8C040008, 2, 9, 32'h114, 0, 0, 0, 0));
    tv.push_back(mk(0, 32'h114, 32'hAC0400C0, 2, 8, 32'h118, 1, 32'hC0, 32'd12, 0));
    tv.push_back(mk(0, 32'h118, 32'h08000000, 0, 3, 32'h0, 0, 0, 0, 0));
    tv.push_back(mk(0, 32'h0, 32'h10210002, 0, 3, 32'hC, 0, 0, 0, 0));
    tv.push_back(mk(0, 32'hC, 32'h14210005, 0, 3, 32'h10, 0, 0, 0, 0));
    tv.push_back(mk(0, 32'h10, 32'h14220003, 0, 3, 32'h20, 0, 0, 0, 0));
    tv.push_back(mk(0, 32'h20, 32'h20000009, 0, 4, 32'h24, 0, 0, 0, 0));
    tv.push_back(mk(0, 32'h24, 32'hAC000080, 0, 4, 32'h28, 1, 32'h80, 32'h0, 0));
    tv.push_back(mk(0, 32'h28, 32'h00222822, 1, 5, 32'h2C, 0, 0, 0, 0));
    tv.push_back(mk(0, 32'h2C, 32'hAC050084, 0, 4, 32'h30, 1, 32'h84, 32'hFFFF_FFFE, 0));
    tv.push_back(mk(0, 32'h30, 32'h00A1302A, 0, 4, 32'h34, 0, 0, 0, 0));
    tv.push_back(mk(0, 32'h34, 32'hAC060088, 0, 4, 32'h38, 1, 32'h88, 32'h1, 0));
    tv.push_back(mk(0, 32'h38, 32'h00223824, 0, 4, 32'h3C, 0, 0, 0, 0));
    tv.push_back(mk(0, 32'h3C, 32'h00224025, 0, 4, 32'h40, 0, 0, 0, 0));
    tv.push_back(mk(0, 32'h40, 32'hAC07008C, 0, 4, 32'h44, 1, 32'h8C, 32'h5, 0));
    tv.push_back(mk(0, 32'h44, 32'hAC080090, 0, 4, 32'h48, 1, 32'h90, 32'h7, 0));
    tv.push_back(mk(0, 32'h48, 32'h00224821, 0, 2, 32'h4C, 0, 0, 0, 1));
    tv.push_back(mk(0, 32'h4C, 32'h3001FFFF, 0, 2, 32'h50, 0, 0, 0, 1));
    tv.push_back(mk(0, 32'h50, 32'hAC010094, 0, 4, 32'h54, 1, 32'h94, 32'h5, 0));
    tv.push_back(mk(1, 32'h1000_0000, 32'h08000040, 0, 3, 32'h1000_0100, 0, 0, 0, 0));
    tv.push_back(mk(1, 32'h1000_0100, 32'h14000004, 0, 2, 32'h1000_0104, 0, 0, 0, 1));
    tv.push_back(mk(1, 32'h1000_0104, 32'h1000FFFE, 0, 3, 32'h1000_0100, 0, 0, 0, 0));
    checks = 0; errors = 0; unstable = 0; waits = 0; sum = 0;
    for (int g = 0; g < 2; g++) begin
      rst[g] = 1'b1; ready[g] = 1'b0; rdata[g] = '0; wcnt[g] = 0;
      ret_tot[g] = 0; ill_tot[g] = 0; hold[g] = 1'b0; wr_seen[g] = 1'b0;
      for (int i = 0; i < 256; i++) mem[g][i] = '0;
    end
    foreach (tv[i]) mem[tv[i].g][tv[i].ia[9:2]] = tv[i].instr;
    repeat (3) cycle();
    chk("reset_req", 32'(req[0]), 0);
    chk("reset_state", 32'(state[0]), 0);
    chk("reset_pc", pc[0], 32'h100);
    chk("reset_pc_cfg1", pc[1], 32'h1000_0000);
    chk("reset_pulses", ret_tot[0] + ill_tot[0], 0);
    rst[0] = 1'b0;
    #1;
    chk("first_req", 32'(req[0]), 1);
    chk("first_addr", addr[0], 32'h100);
    chk("first_we", 32'(we[0]), 0);
    for (int i = 0; i < 23; i++) begin
      apply(tv[i], cyc);
      if (i < 3) sum += cyc;
      if (i == 2) begin
        chk("addi_addi_add_total_cycles", sum, 12);
        chk("addi_addi_add_retires", ret_tot[0], 3);
      end
    end
    chk("addr_stable_in_waits", unstable, 0);
    mem[0][21] = 32'h8C0100C0;
    waits = 3;
    cyc = 0;
    while (state[0] != 4'd3 && cyc < 20) begin
      cycle();
      cyc++;
    end
    chk("reach_memrd", 32'(state[0]), 3);
    cycle();
    r0 = ret_tot[0];
    rst[0] = 1'b1;
    #1;
    chk("abort_req_now", 32'(req[0]), 0);
    cycle();
    chk("abort_req_next", 32'(req[0]), 0);
    chk("abort_state", 32'(state[0]), 0);
    chk("abort_pc", pc[0], 32'h100);
    chk("abort_no_retire", ret_tot[0] - r0, 0);
    mem[0][64] = 32'hAC010098;
    waits = 0;
    rst[0] = 1'b0;
    run(0, cyc);
    chk("abort_rf_seen", 32'(wr_seen[0]), 1);
    chk("abort_rf_addr", wr_addr[0], 32'h98);
    chk("abort_rf_kept", wr_data[0], 32'h5);
    rst[0] = 1'b1;
    rst[1] = 1'b0;
    for (int i = 23; i < 26; i++) apply(tv[i], cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
